// File: rtl/wb_interconnect_pkg.sv
// rtl/wb_interconnect_pkg.sv - shared FSM encoding and default memory map for wb_interconnect
package wb_defs;

  localparam int WB_AW      = 32;
  localparam int WB_DW      = 32;
  localparam int WB_NSLAVES = 4;

  // Slave 0 sits in the least significant word; a zero mask leaves that port unmapped
  localparam logic [WB_NSLAVES*WB_AW-1:0] WB_SLAVE_BASE =
    {32'hc0000000, 32'hb0008000, 32'hb0000000, 32'h00000000};
  localparam logic [WB_NSLAVES*WB_AW-1:0] WB_SLAVE_MASK =
    {32'hffff0000, 32'hffff8000, 32'hffff8000, 32'h00000000};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_interconnect_if.sv
// rtl/wb_interconnect_if.sv - master-side bus bundle of wb_interconnect
interface wb_interconnect_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_wb_cyc;
  logic          i_wb_stb;
  logic          i_wb_we;
  logic [AW-1:0] i_wb_addr;
  logic [DW-1:0] i_wb_data;
  logic [DW/8-1:0] i_wb_sel;
  logic [DW-1:0] o_wb_data;
  logic          o_wb_ack;
  logic          o_wb_stl;
  logic          o_wb_err;

  // Bus master driving requests into the interconnect
  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_data, o_wb_ack, o_wb_stl, o_wb_err
  );

  // Interconnect side, which looks like a slave to the master
  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_data, o_wb_ack, o_wb_stl, o_wb_err
  );
endinterface

// File: rtl/wb_interconnect_addr_decoder.sv
// rtl/wb_interconnect_addr_decoder.sv - priority base/mask address decoder
module wb_addr_decoder #(
  parameter int NSLAVES = 4,
  parameter int AW      = 32,
  parameter int IW      = 2,
  parameter logic [NSLAVES*AW-1:0] BASE = '0,
  parameter logic [NSLAVES*AW-1:0] MASK = '0
) (
  input  logic [AW-1:0] i_addr,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  // Scan from the top down so the lowest matching slave is the one left standing
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = NSLAVES - 1; k >= 0; k--) begin
      if ((MASK[k*AW +: AW] != '0) &&
          ((i_addr & MASK[k*AW +: AW]) == BASE[k*AW +: AW])) begin
        o_valid = 1'b1;
        o_idx   = IW'(k);
      end
    end
  end

endmodule

// File: rtl/wb_interconnect.sv
// rtl/wb_interconnect.sv - single-master Wishbone interconnect; WB_INTERCONNECT_TIMEOUT_EN adds a BUSY watchdog
module wb_interconnect
  import wb_defs::*;
#(
  parameter int NSLAVES = WB_NSLAVES,
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter logic [NSLAVES*AW-1:0] SLAVE_BASE = WB_SLAVE_BASE,
  parameter logic [NSLAVES*AW-1:0] SLAVE_MASK = WB_SLAVE_MASK,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  wb_interconnect_if.slave      io_wb,
  output logic [AW-1:0]         o_s_addr,
  output logic [DW-1:0]         o_s_data,
  output logic [DW/8-1:0]       o_s_sel,
  output logic                  o_s_we,
  output logic [NSLAVES-1:0]    o_s_cyc,
  output logic [NSLAVES-1:0]    o_s_stb,
  input  logic [NSLAVES-1:0]    i_s_ack,
  input  logic [NSLAVES-1:0]    i_s_stl,
  input  logic [NSLAVES*DW-1:0] i_s_data
);

  localparam int IW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_timeout_out_of_range
  end

  wb_state_e       r_state;
  logic [IW-1:0]   r_idx;
  logic            r_err;
  logic            w_dec_valid;
  logic [IW-1:0]   w_dec_idx;
  logic            w_req;
  logic            w_dec_stl;
  logic            w_s_ack;
`ifdef WB_INTERCONNECT_TIMEOUT_EN
  logic [15:0]     r_tmo_cnt;
`endif

  wb_addr_decoder #(
    .NSLAVES (NSLAVES),
    .AW      (AW),
    .IW      (IW),
    .BASE    (SLAVE_BASE),
    .MASK    (SLAVE_MASK)
  ) u_dec (
    .i_addr  (io_wb.i_wb_addr),
    .o_valid (w_dec_valid),
    .o_idx   (w_dec_idx)
  );

  assign w_req     = io_wb.i_wb_cyc & io_wb.i_wb_stb;
  assign w_dec_stl = i_s_stl[w_dec_idx];
  assign w_s_ack   = i_s_ack[r_idx];

  assign o_s_addr = io_wb.i_wb_addr;
  assign o_s_data = io_wb.i_wb_data;
  assign o_s_sel  = io_wb.i_wb_sel;
  assign o_s_we   = io_wb.i_wb_we;

  assign io_wb.o_wb_err = r_err;

  // Transaction FSM: latch the target on acceptance, release on ack, abort or error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_err     <= 1'b0;
`ifdef WB_INTERCONNECT_TIMEOUT_EN
      r_tmo_cnt <= '0;
`endif
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            if (!w_dec_valid) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end else if (!w_dec_stl) begin
              r_state   <= ST_BUSY;
              r_idx     <= w_dec_idx;
`ifdef WB_INTERCONNECT_TIMEOUT_EN
              r_tmo_cnt <= '0;
`endif
            end
          end
        end
        ST_BUSY: begin
          if (!io_wb.i_wb_cyc || w_s_ack) begin
            r_state <= ST_IDLE;
          end
`ifdef WB_INTERCONNECT_TIMEOUT_EN
          else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
            if (r_tmo_cnt == 16'(TIMEOUT - 1)) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end
`endif
        end
        ST_ERR:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Route strobes and returns; everything toward the master or slaves is held low during reset
  always_comb begin
    o_s_cyc         = '0;
    o_s_stb         = '0;
    io_wb.o_wb_ack  = 1'b0;
    io_wb.o_wb_stl  = 1'b0;
    io_wb.o_wb_data = '0;
    if (reset) begin
      case (r_state)
        ST_IDLE: begin
          if (w_dec_valid) begin
            o_s_cyc[w_dec_idx] = io_wb.i_wb_cyc;
            o_s_stb[w_dec_idx] = w_req;
            io_wb.o_wb_stl     = w_dec_stl;
          end
        end
        ST_BUSY: begin
          io_wb.o_wb_stl = 1'b1;
          o_s_cyc[r_idx] = io_wb.i_wb_cyc;
          if (io_wb.i_wb_cyc && w_s_ack) begin
            io_wb.o_wb_ack  = 1'b1;
            io_wb.o_wb_data = i_s_data[r_idx*DW +: DW];
          end
        end
        ST_ERR:  io_wb.o_wb_stl = 1'b1;
        default: io_wb.o_wb_stl = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_interconnect.sv
// tb/tb_wb_interconnect.sv - randomized and directed bench for wb_interconnect against a transaction model
module tb_wb_interconnect;

  localparam int TMO = 8;
`ifdef WB_INTERCONNECT_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_sel;
  logic         s_we;
  logic [3:0]   s_cyc, s_stb;
  logic [3:0]   s_ack = '0;
  logic [3:0]   s_stl = '0;
  logic [127:0] s_rdata = '0;

  wb_interconnect_if #(.AW(32), .DW(32)) bus ();

  wb_interconnect #(.TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .io_wb    (bus),
    .o_s_addr (s_addr),
    .o_s_data (s_wdata),
    .o_s_sel  (s_sel),
    .o_s_we   (s_we),
    .o_s_cyc  (s_cyc),
    .o_s_stb  (s_stb),
    .i_s_ack  (s_ack),
    .i_s_stl  (s_stl),
    .i_s_data (s_rdata)
  );

  always #5 clk = ~clk;

  // Memory map written out from the default base/mask words
  logic [31:0] map_base [4] = '{32'h00000000, 32'hb0000000, 32'hb0008000, 32'hc0000000};
  logic [31:0] map_mask [4] = '{32'h00000000, 32'hffff8000, 32'hffff8000, 32'hffff0000};

  int n_tests = 0;
  int n_fail  = 0;

  // Model: which slave owns the outstanding transaction (-1 none), pending error, BUSY age
  int m_sel = -1;
  bit m_err = 1'b0;
  int m_cnt = 0;

  int          n_ack, n_err, n_stl;
  logic [31:0] last_data;
  logic [3:0]  stb_seen;

  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < 4; k++)
      if (map_mask[k] != 0 && (a & map_mask[k]) == map_base[k]) return k;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_stats();
    n_ack = 0; n_err = 0; n_stl = 0; last_data = '0; stb_seen = '0;
  endtask

  // Check outputs at the falling edge, then advance the model for the coming rising edge
  task automatic step();
    logic [3:0]  e_cyc, e_stb;
    logic        e_ack, e_stl, e_err;
    logic [31:0] e_data;
    int          d;
    @(negedge clk);
    e_cyc = '0; e_stb = '0; e_ack = 1'b0; e_stl = 1'b0; e_err = 1'b0; e_data = '0;
    if (reset) begin
      e_err = m_err;
      if (m_err) begin
        e_stl = 1'b1;
      end else if (m_sel >= 0) begin
        e_stl = 1'b1;
        e_cyc[m_sel] = bus.i_wb_cyc;
        e_ack = bus.i_wb_cyc & s_ack[m_sel];
        if (e_ack) e_data = s_rdata[m_sel*32 +: 32];
      end else begin
        d = decode(bus.i_wb_addr);
        if (d >= 0) begin
          e_cyc[d] = bus.i_wb_cyc;
          e_stb[d] = bus.i_wb_cyc & bus.i_wb_stb;
          e_stl = s_stl[d];
        end
      end
    end
    chk("ack",   64'(bus.o_wb_ack),  64'(e_ack));
    chk("err",   64'(bus.o_wb_err),  64'(e_err));
    chk("stl",   64'(bus.o_wb_stl),  64'(e_stl));
    chk("rdata", 64'(bus.o_wb_data), 64'(e_data));
    chk("s_cyc", 64'(s_cyc), 64'(e_cyc));
    chk("s_stb", 64'(s_stb), 64'(e_stb));
    chk("s_addr", 64'(s_addr),  64'(bus.i_wb_addr));
    chk("s_data", 64'(s_wdata), 64'(bus.i_wb_data));
    chk("s_sel",  64'(s_sel),   64'(bus.i_wb_sel));
    chk("s_we",   64'(s_we),    64'(bus.i_wb_we));
    if (bus.o_wb_ack) begin n_ack++; last_data = bus.o_wb_data; end
    if (bus.o_wb_err) n_err++;
    if (bus.o_wb_stl) n_stl++;
    stb_seen |= s_stb;
    if (!reset) begin
      m_sel = -1; m_err = 1'b0; m_cnt = 0;
    end else if (m_err) begin
      m_err = 1'b0;
    end else if (m_sel >= 0) begin
      if (!bus.i_wb_cyc || e_ack) m_sel = -1;
      else begin
        m_cnt++;
        if (TMO_EN && m_cnt == TMO) begin m_sel = -1; m_err = 1'b1; end
      end
    end else if (bus.i_wb_cyc && bus.i_wb_stb) begin
      d = decode(bus.i_wb_addr);
      if (d < 0) m_err = 1'b1;
      else if (!s_stl[d]) begin m_sel = d; m_cnt = 0; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic we, input logic [31:0] wd);
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = we;
    bus.i_wb_addr = a; bus.i_wb_data = wd; bus.i_wb_sel = 4'hf;
  endtask

  task automatic idle_all();
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; s_ack = '0; s_stl = '0;
  endtask

  initial begin
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
    bus.i_wb_addr = '0; bus.i_wb_data = '0; bus.i_wb_sel = '0;
    clr_stats();
    @(posedge clk); #1;
    req(32'hb0000010, 1'b0, 32'h0);
    step(); step();
    reset = 1'b1;
    idle_all();
    step();

    // Read to 0xb0000010 (slave 1), ack two cycles after acceptance
    clr_stats();
    req(32'hb0000010, 1'b0, 32'h0);
    step();
    bus.i_wb_stb = 1'b0;
    step();
    s_ack[1] = 1'b1; s_rdata[32 +: 32] = 32'hdeadbeef;
    step();
    idle_all();
    step();
    chk("rd_acks", 64'(n_ack), 64'd1);
    chk("rd_data", 64'(last_data), 64'hdeadbeef);
    chk("rd_stb_seen", 64'(stb_seen), 64'h2);

    // Write to 0xc0000000 with slave 3 stalling three cycles
    clr_stats();
    req(32'hc0000000, 1'b1, 32'h41);
    s_stl[3] = 1'b1;
    step(); step(); step();
    s_stl[3] = 1'b0;
    step();
    bus.i_wb_stb = 1'b0; s_ack[3] = 1'b1;
    step();
    idle_all();
    step();
    chk("wr_stl_cycles", 64'(n_stl), 64'd4);
    chk("wr_acks", 64'(n_ack), 64'd1);

    // Unmapped access
    clr_stats();
    req(32'ha0000000, 1'b0, 32'h0);
    step();
    bus.i_wb_stb = 1'b0;
    step(); step();
    idle_all();
    step();
    chk("unmapped_errs", 64'(n_err), 64'd1);
    chk("unmapped_stb", 64'(stb_seen), 64'h0);
    chk("unmapped_acks", 64'(n_ack), 64'd0);

    // Slave 2 never acks; watchdog fires only when enabled
    clr_stats();
    req(32'hb0008000, 1'b0, 32'h0);
    step();
    bus.i_wb_stb = 1'b0;
    repeat (100) step();
    idle_all();
    step();
    chk("hang_errs", 64'(n_err), TMO_EN ? 64'd1 : 64'd0);
    chk("hang_acks", 64'(n_ack), 64'd0);

    // Spurious ack from slave 2 while slave 1 is selected, then abort and late ack
    clr_stats();
    req(32'hb0000100, 1'b0, 32'h0);
    step();
    bus.i_wb_stb = 1'b0; s_ack[2] = 1'b1;
    step();
    s_ack[2] = 1'b0; bus.i_wb_cyc = 1'b0;
    step();
    s_ack[1] = 1'b1;
    step();
    idle_all();
    step();
    chk("abort_acks", 64'(n_ack), 64'd0);
    chk("abort_errs", 64'(n_err), 64'd0);

    // Reset mid-BUSY, then a fresh read to slave 2
    clr_stats();
    req(32'hb0000000, 1'b0, 32'h0);
    step();
    bus.i_wb_stb = 1'b0;
    step();
    s_ack[1] = 1'b1; s_rdata[32 +: 32] = 32'h55aa55aa;
    reset = 1'b0;
    #1;
    chk("rst_async_cyc", 64'(s_cyc), 64'h0);
    chk("rst_async_ack", 64'(bus.o_wb_ack), 64'd0);
    step();
    reset = 1'b1;
    step();
    req(32'hb0008000, 1'b0, 32'h0);
    step();
    bus.i_wb_stb = 1'b0; s_ack[2] = 1'b1; s_rdata[64 +: 32] = 32'h12345678;
    step();
    idle_all();
    step();
    chk("post_rst_acks", 64'(n_ack), 64'd1);
    chk("post_rst_data", 64'(last_data), 64'h12345678);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 19) == 0) bus.i_wb_cyc = ~bus.i_wb_cyc;
      bus.i_wb_stb  = ($urandom_range(0, 9) < 4);
      bus.i_wb_we   = $urandom_range(0, 1);
      bus.i_wb_data = $urandom;
      bus.i_wb_sel  = 4'($urandom);
      case ($urandom_range(0, 4))
        0:       bus.i_wb_addr = 32'hb0000000 | 32'($urandom_range(0, 32'h7fff));
        1:       bus.i_wb_addr = 32'hb0008000 | 32'($urandom_range(0, 32'h7fff));
        2:       bus.i_wb_addr = 32'hc0000000 | 32'($urandom_range(0, 32'hffff));
        3:       bus.i_wb_addr = 32'ha0000000 | 32'($urandom_range(0, 32'hffff));
        default: bus.i_wb_addr = $urandom;
      endcase
      for (int k = 0; k < 4; k++) begin
        s_stl[k] = ($urandom_range(0, 3) == 0);
        s_ack[k] = ($urandom_range(0, 3) == 0);
        s_rdata[k*32 +: 32] = $urandom;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
